// File: rtl/mem_port_arbiter_if.sv
// Bundle of every request, response, memory and MMIO signal of the
// fetch / load-store memory port arbiter.
// slave  : the arbiter side (takes requests, drives memory and MMIO).
// master : the requester / memory side (drives requests and mem_rdata).
interface mem_port_arbiter_if #(
  parameter int MEMORY_BITS = 10
);
  // Fetch requester
  logic                   if_req_valid;
  logic [31:0]            if_addr;
  logic                   if_req_ready;
  logic                   if_resp_valid;
  logic [31:0]            if_rdata;
  // Load/store requester
  logic                   d_req_valid;
  logic                   d_we;
  logic [3:0]             d_be;
  logic [31:0]            d_addr;
  logic [31:0]            d_wdata;
  logic                   d_req_ready;
  logic                   d_resp_valid;
  logic [31:0]            d_rdata;
  // Single-port word memory
  logic                   mem_en;
  logic                   mem_we;
  logic [3:0]             mem_be;
  logic [MEMORY_BITS-1:0] mem_addr;
  logic [31:0]            mem_wdata;
  logic [31:0]            mem_rdata;
  // MMIO side effects
  logic                   mmio_putc_valid;
  logic [7:0]             mmio_putc_char;
  logic                   mmio_exit_valid;
  logic [31:0]            mmio_exit_code;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_resp_valid, if_rdata,
    input  d_req_valid, d_we, d_be, d_addr, d_wdata,
    output d_req_ready, d_resp_valid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata,
    output mmio_putc_valid, mmio_putc_char, mmio_exit_valid, mmio_exit_code
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_resp_valid, if_rdata,
    output d_req_valid, d_we, d_be, d_addr, d_wdata,
    input  d_req_ready, d_resp_valid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata,
    input  mmio_putc_valid, mmio_putc_char, mmio_exit_valid, mmio_exit_code
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous word memory between the instruction
// fetch requester and the load/store requester, one grant per cycle, with
// the read response one cycle after the grant. Stores to the console and
// exit MMIO addresses are turned into one-cycle pulses instead of memory
// writes.
// Optional build macro: ARB_STATS_EN adds free-running grant/conflict
// counters (stat_if_grants, stat_d_grants, stat_conflicts).
//
// Handshake: a requester raises *_req_valid and holds valid, address and
// data stable until it sees *_req_ready high; ready high means the request
// is consumed at that rising edge. At most one ready is high per cycle.
// The matching *_resp_valid is high for exactly the cycle after that edge.
module mem_port_arbiter #(
  parameter int          MEMORY_LEN      = 1024,
  parameter int          MEMORY_BITS     = $clog2(MEMORY_LEN),
  parameter int          MAX_DATA_STREAK = 4,
  parameter logic [31:0] MMIO_PUTC_ADDR  = 32'hFFFF0000,
  parameter logic [31:0] MMIO_EXIT_ADDR  = 32'hABCD0000
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           dbg_owner_o
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]          stat_if_grants,
  output logic [31:0]          stat_d_grants,
  output logic [31:0]          stat_conflicts
`endif
);

  // Who owns the response slot in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  owner_e     owner_q, owner_d;
  logic       d_store_q, d_store_d;
  logic [3:0] streak_q, streak_d;

  logic       grant_if;
  logic       grant_d;
  logic       streak_full;
  logic       is_putc;
  logic       is_exit;
  logic       mmio_store;

  // Address bits outside the word index are not used by the memory path.
  logic unused_if_addr_bits;
  assign unused_if_addr_bits = ^{bus.if_addr[31:MEMORY_BITS+2], bus.if_addr[1:0]};

  // Arbitration: data wins unless fetch has waited MAX_DATA_STREAK data
  // grants in a row; reset blocks every grant so outputs drop at once.
  always_comb begin
    streak_full = (streak_q == STREAK_MAX);
    grant_d     = 1'b0;
    grant_if    = 1'b0;
    if (!rst) begin
      grant_d  = bus.d_req_valid && !(bus.if_req_valid && streak_full);
      grant_if = bus.if_req_valid && !grant_d;
    end
    is_putc    = (bus.d_addr == MMIO_PUTC_ADDR);
    is_exit    = (bus.d_addr == MMIO_EXIT_ADDR);
    mmio_store = bus.d_we && (is_putc || is_exit);
  end

  // Request-side outputs: readies, memory strobe and MMIO pulses.
  always_comb begin
    bus.if_req_ready    = grant_if;
    bus.d_req_ready     = grant_d;
    bus.mem_en          = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_be          = 4'h0;
    bus.mem_addr        = '0;
    bus.mem_wdata       = 32'h0;
    bus.mmio_putc_valid = 1'b0;
    bus.mmio_putc_char  = 8'h0;
    bus.mmio_exit_valid = 1'b0;
    bus.mmio_exit_code  = 32'h0;
    if (grant_if) begin
      bus.mem_en   = 1'b1;
      bus.mem_be   = 4'hF;
      bus.mem_addr = bus.if_addr[MEMORY_BITS+1:2];
    end else if (grant_d) begin
      if (mmio_store) begin
        bus.mmio_putc_valid = is_putc;
        bus.mmio_putc_char  = is_putc ? bus.d_wdata[7:0] : 8'h0;
        bus.mmio_exit_valid = is_exit;
        bus.mmio_exit_code  = is_exit ? bus.d_wdata : 32'h0;
      end else begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.d_we;
        bus.mem_be    = bus.d_we ? bus.d_be : 4'hF;
        bus.mem_addr  = bus.d_addr[MEMORY_BITS+1:2];
        bus.mem_wdata = bus.d_we ? bus.d_wdata : 32'h0;
      end
    end
  end

  // Next owner, store flag and fetch-starvation streak.
  always_comb begin
    owner_d   = OWN_NONE;
    d_store_d = 1'b0;
    streak_d  = streak_q;
    if (grant_if) begin
      owner_d = OWN_IF;
    end else if (grant_d) begin
      owner_d   = OWN_D;
      d_store_d = bus.d_we;
    end
    if (!bus.if_req_valid || grant_if) begin
      streak_d = 4'h0;
    end else if (grant_d && !streak_full) begin
      streak_d = streak_q + 4'h1;
    end
  end

  // Response owner and streak registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      d_store_q <= 1'b0;
      streak_q  <= 4'h0;
    end else begin
      owner_q   <= owner_d;
      d_store_q <= d_store_d;
      streak_q  <= streak_d;
    end
  end

  // Response steering: memory data goes to whichever requester owns the slot;
  // stores (including MMIO) answer with zero data.
  always_comb begin
    bus.if_resp_valid = (owner_q == OWN_IF);
    bus.d_resp_valid  = (owner_q == OWN_D);
    bus.if_rdata      = (owner_q == OWN_IF) ? bus.mem_rdata : 32'h0;
    bus.d_rdata       = (owner_q == OWN_D && !d_store_q) ? bus.mem_rdata : 32'h0;
    dbg_owner_o       = owner_q;
  end

`ifdef ARB_STATS_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_if_grants <= 32'h0;
      stat_d_grants  <= 32'h0;
      stat_conflicts <= 32'h0;
    end else begin
      if (grant_if) stat_if_grants <= stat_if_grants + 32'h1;
      if (grant_d) stat_d_grants <= stat_d_grants + 32'h1;
      if (bus.if_req_valid && bus.d_req_valid) stat_conflicts <= stat_conflicts + 32'h1;
    end
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified word memory between the core's instruction-fetch requester and its load/store requester.
- Decodes the MMIO addresses (console character, program exit) and steers those accesses away from memory.
- Pipelined: it can grant one request per cycle, and the read response arrives one cycle after the grant.
- Sits between the fetch/LSU front ends and the memory array; it replaces direct array indexing once the core is split into fetch and execute stages.

Parameters:
- MEMORY_LEN, 1024, memory depth in 32-bit words.
- MEMORY_BITS, $clog2(MEMORY_LEN), word-address width.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits before fetch is forced through (range 1..15).
- MMIO_PUTC_ADDR, 32'hFFFF0000, console character write address.
- MMIO_EXIT_ADDR, 32'hABCD0000, program-exit write address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_addr  in  32  fetch byte address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_resp_valid  out  1  fetch data valid.
- if_rdata  out  32  fetched word.
- d_req_valid  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, already lane-aligned.
- d_req_ready  out  1  data request accepted this cycle.
- d_resp_valid  out  1  load data valid, or store acknowledge.
- d_rdata  out  32  loaded word (0 for stores and MMIO).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  MEMORY_BITS  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  synchronous read data, valid the cycle after mem_en.
- mmio_putc_valid  out  1  one-cycle pulse carrying a console character.
- mmio_putc_char  out  8  character (d_wdata[7:0]).
- mmio_exit_valid  out  1  one-cycle pulse: program exit.
- mmio_exit_code  out  32  exit code (d_wdata).

Behaviour:
- Reset: all outputs 0; streak counter 0; response-owner register set to NONE. Reset asserted mid-transaction drops the in-flight response; no resp_valid fires after reset.
- Grant (combinational, each cycle):
  - Only data valid → grant data.
  - Only fetch valid → grant fetch.
  - Both valid → grant data, unless streak == MAX_DATA_STREAK, then grant fetch.
- At most one ready high per cycle. A ready high means the request was consumed at that edge. Requesters hold valid, addr and data stable until ready.
- Streak counter:
  - Increments on a data grant while fetch is valid.
  - Clears on any fetch grant, or on any cycle with fetch not valid.
  - Saturates at MAX_DATA_STREAK.
- Memory drive on grant: mem_en = 1; mem_addr = addr[MEMORY_BITS+1:2] (wraps modulo MEMORY_LEN); addr[1:0] ignored.
  - Fetch: mem_we = 0, mem_be = 4'hF.
  - Data: mem_we = d_we, mem_be = d_we ? d_be : 4'hF.
- MMIO decode: a data store whose full d_addr equals an MMIO address does not touch memory (mem_en = 0). The matching mmio_*_valid pulses in the grant cycle.
  - MMIO stores still get ready and, next cycle, d_resp_valid with d_rdata = 0.
  - Loads from MMIO addresses go to memory normally.
- Response, registered: the owner register records the grant (IF / D / NONE).
  - The next cycle raises exactly one of if_resp_valid / d_resp_valid for one cycle.
  - if_rdata = mem_rdata.
  - d_rdata = mem_rdata for loads, 0 for stores.
- Throughput: back-to-back grants every cycle; response latency exactly 1 cycle after the grant edge.
- Nothing is granted when neither requester is valid; the owner becomes NONE and no resp_valid fires.

Optional Feature:
- ARB_STATS_EN defined: adds outputs stat_if_grants (32), stat_d_grants (32) and stat_conflicts (32, cycles with both requesters valid).
  - All three reset to 0, increment on the relevant event, and wrap at 2^32.
- ARB_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Fetch only, if_addr = 0x10 held 3 cycles → if_req_ready = 1 every cycle; mem_addr = 4; if_resp_valid each following cycle with memory contents.
- Data store d_addr = 0x22, d_be = 4'b0100, d_wdata = 0x00AB0000 → mem_we = 1, mem_be = 4'b0100, mem_addr = 8; next cycle d_resp_valid = 1, d_rdata = 0.
- Both valid continuously, MAX_DATA_STREAK = 4 → grant pattern D,D,D,D,IF repeating; fetch is never starved.
- Store to 0xFFFF0000 with wdata = 0x41 → mmio_putc_valid pulse, char = 'A', mem_en = 0; d_resp_valid the next cycle.
- Store to 0xABCD0000 with wdata = 7 → mmio_exit_valid pulse, exit_code = 7; no memory write.
- Reset asserted one cycle after a fetch grant → no if_resp_valid; all outputs 0 immediately (asynchronous).
